hilo_unit: RTL
==============

# hilo_unit

HI/LO register pair and iterative multiply/divide engine serving the EX stage. Accepts mult/multu/div/divu requests from EX, computes them over a fixed number of cycles while signalling busy (pipeline stall), and writes the 64-bit result into HI/LO. Also accepts direct HI/LO writes (mthi/mtlo) and supplies HI/LO read data to EX for mfhi/mflo, with same-cycle bypass of direct writes.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO register width; all arithmetic below assumes 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a multiply/divide; sampled only when busy=0
- mdOp  in  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
- regaData  in  32  operand A (multiplicand / dividend)
- regbData  in  32  operand B (multiplier / divisor)
- whi  in  1  direct HI write enable (mthi)
- wHiData  in  32  direct HI write data
- wlo  in  1  direct LO write enable (mtlo)
- wLoData  in  32  direct LO write data
- rHiData  out  32  HI read data to EX (bypassed)
- rLoData  out  32  LO read data to EX (bypassed)
- busy  out  1  operation in progress; EX/ID stall while high
- done  out  1  one-cycle pulse: HI/LO updated with result at the preceding edge
- divZero  out  1  one-cycle pulse coinciding with done for div/divu with regbData=0

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: start=1 at an edge -> latch mdOp, magnitudes |A|,|B| (signed ops) or raw A,B (unsigned ops), result-sign flags (mult: signA^signB; div: quotient signA^signB, remainder signA); clear 64-bit accumulator; counter=0; go CALC. If div/divu and B=0: go FINISH directly.
- CALC: one iteration per cycle, 32 iterations, counter 0..31, then FINISH.
  - Multiply: radix-2 shift-add on magnitudes; 64-bit unsigned product.
  - Divide: restoring division on magnitudes; 32-bit quotient and remainder.
- FINISH (one cycle): apply sign fix (two's-complement negate where flagged), write HI/LO, pulse done (and divZero), return IDLE.
- Result mapping: mult/multu HI=product[63:32], LO=product[31:0]; div/divu LO=quotient, HI=remainder (remainder takes dividend sign).
- Divide by zero: HI=dividend (regaData as latched), LO=32'hFFFF_FFFF, divZero=1.
- Signed div 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0 (wraps, no trap).
- Direct writes: whi/wlo update HI/LO at the edge in any state. If FINISH writes at the same edge, FINISH result wins.
- start while busy=1 is ignored; start together with whi/wlo in IDLE: direct write applies now, operation result overwrites later.
- Reads: rHiData = whi ? wHiData : HI; rLoData = wlo ? wLoData : LO (combinational bypass). During busy, reads return current HI/LO (stale by design; stall prevents use).

## Timing
- Reset (async, immediate): HI=0, LO=0, state=IDLE, counter=0, busy=0, done=0, divZero=0; in-flight operation abandoned, no write.
- busy is registered: 0 in IDLE, 1 in CALC and FINISH.
- Normal op: start sampled at edge E0 -> CALC during E1..E32 -> FINISH edge E33 writes HI/LO; done=1 and busy=0 in cycle after E33. Next start accepted at E34 earliest? No: start accepted at E33 edge is not allowed (busy=1 before E33); earliest next accept is E34.
- Divide by zero: start at E0 -> FINISH write at E1; done/divZero high in cycle after E1.
- done and divZero are single-cycle pulses, cleared at next edge.

## Test plan
- mult, A=32'hFFFF_FFFD (-3), B=7 -> after E33: HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB, done pulse exactly once, busy high 33 cycles.
- multu, A=B=32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001; mult same operands -> HI=0, LO=1.
- div, A=-7 (32'hFFFF_FFF9), B=2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; divu A=100, B=7 -> LO=14, HI=2; div 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
- divu A=32'h1234_5678, B=0 -> at E1: HI=32'h1234_5678, LO=32'hFFFF_FFFF, done=divZero=1 one cycle, busy=0 after.
- whi=1, wHiData=32'hDEAD_BEEF in IDLE -> rHiData=32'hDEAD_BEEF same cycle, HI holds it after edge; whi at same edge as FINISH -> HI takes result; start while busy ignored (no second done).
- Assert rst at CALC counter=10 -> immediately busy=0, HI=LO=0, no done; new start after deassert completes normally in 33 cycles.

Source files
------------

// File: rtl/hilo_unit_if.sv
// hilo_unit_if: request/response bundle between the EX stage and hilo_unit.
//   master (EX side)  : drives start, mdOp, regaData, regbData,
//                       whi/wHiData, wlo/wLoData; receives rHiData, rLoData,
//                       busy, done, divZero.
//   slave  (hilo_unit): the mirror image.
interface hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       mdOp;
  logic [WIDTH-1:0] regaData;
  logic [WIDTH-1:0] regbData;
  logic             whi;
  logic [WIDTH-1:0] wHiData;
  logic             wlo;
  logic [WIDTH-1:0] wLoData;
  logic [WIDTH-1:0] rHiData;
  logic [WIDTH-1:0] rLoData;
  logic             busy;
  logic             done;
  logic             divZero;

  modport master (
    output start, mdOp, regaData, regbData, whi, wHiData, wlo, wLoData,
    input  rHiData, rLoData, busy, done, divZero
  );

  modport slave (
    input  start, mdOp, regaData, regbData, whi, wHiData, wlo, wLoData,
    output rHiData, rLoData, busy, done, divZero
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with an iterative multiply/divide engine.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : hilo_unit_if.slave
//          start/mdOp/regaData/regbData  - mult, multu, div, divu request
//          whi/wHiData, wlo/wLoData      - direct HI/LO writes (mthi/mtlo)
//          rHiData/rLoData               - HI/LO read data, bypassing
//                                          same-cycle direct writes
//          busy                          - operation in flight (stall)
//          done/divZero                  - one-cycle completion pulses
// One iteration per cycle for WIDTH cycles, then a FINISH cycle that applies
// the sign fix-up and writes HI/LO.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  hilo_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic               is_div_reg;
  logic               neg_q_reg;   // negate product / quotient
  logic               neg_r_reg;   // negate remainder
  logic               dz_reg;      // current op is a divide by zero
  logic [2*WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier_reg;  // multiplier (shifted right) or divisor
  logic [2*WIDTH-1:0] acc_reg;     // product, or {remainder, quotient}
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               divz_reg;

  // Operand magnitudes: signed ops (mdOp[0]=0) work on |A|, |B|.
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = ~bus.mdOp[0];
  assign a_neg     = signed_op & bus.regaData[WIDTH-1];
  assign b_neg     = signed_op & bus.regbData[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.regaData + 1'b1) : bus.regaData;
  assign b_mag     = b_neg ? (~bus.regbData + 1'b1) : bus.regbData;

  // Restoring divide step: shift {rem, quo} left one bit and try to
  // subtract the divisor from the widened partial remainder.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_diff;

  assign rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, mplier_reg};

  // Sign fix-up applied in FINISH.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
  assign quo_fix  = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      divz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      divz_reg <= 1'b0;

      // Direct writes first so a FINISH write at the same edge overrides them.
      if (bus.whi) hi_reg <= bus.wHiData;
      if (bus.wlo) lo_reg <= bus.wLoData;

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            is_div_reg <= bus.mdOp[1];
            count_reg  <= '0;
            busy_reg   <= 1'b1;
            mplier_reg <= b_mag;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            if (bus.mdOp[1]) begin
              mcand_reg <= '0;
              if (bus.regbData == '0) begin
                // Preload the divide-by-zero result; no sign fix applies.
                dz_reg    <= 1'b1;
                neg_q_reg <= 1'b0;
                neg_r_reg <= 1'b0;
                acc_reg   <= {bus.regaData, {WIDTH{1'b1}}};
                state_reg <= FINISH;
              end else begin
                dz_reg    <= 1'b0;
                acc_reg   <= {{WIDTH{1'b0}}, a_mag};  // remainder 0, dividend
                state_reg <= CALC;
              end
            end else begin
              dz_reg    <= 1'b0;
              mcand_reg <= {{WIDTH{1'b0}}, a_mag};
              acc_reg   <= '0;
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          if (is_div_reg) begin
            if (!rem_diff[WIDTH])
              acc_reg <= {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
            else
              acc_reg <= {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
          end else begin
            if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
          end
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) state_reg <= FINISH;
        end

        FINISH: begin
          if (is_div_reg) begin
            lo_reg <= quo_fix;
            hi_reg <= rem_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
          done_reg  <= 1'b1;
          divz_reg  <= dz_reg;
          dz_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          count_reg <= '0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rHiData = bus.whi ? bus.wHiData : hi_reg;
  assign bus.rLoData = bus.wlo ? bus.wLoData : lo_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.divZero = divz_reg;
endmodule
